// File: rtl/apb4_plic_claimer.sv
// apb4_plic_claimer: APB4 initiator for the hart side of a PLIC.
//   On ext_irq_i it reads CLAIMCOMP and presents the ID to the core. When the
//   core signals irq_done_i, it writes the ID back to CLAIMCOMP. Generic core
//   register accesses share the same APB4 bus. A token alternates between
//   claim and generic traffic so neither can starve the other.
// Configuration macro: APB4_PLIC_TIMEOUT_EN. When defined, an ACCESS phase
//   with TIMEOUT cycles of pready=0 is aborted and reported as an error.
// Ports:
//   pclk, preset           clock, synchronous active-high reset
//   ext_irq_i              PLIC external interrupt request (level)
//   irq_valid_o, irq_id_o  claimed ID presented to the core
//   irq_done_i             core handler finished; starts the completion write
//   req_*_i, req_ready_o   generic access request and its accept pulse
//   rsp_*_o                generic access response (rsp_valid_o is a pulse)
//   err_o                  pulse on a claim/complete transfer error
//   paddr..pstrb           APB4 master outputs
//   pready, prdata, pslverr APB4 master inputs
module apb4_plic_claimer #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ID_WIDTH     = 5,
    parameter logic [ADDR_WIDTH-1:0] PLIC_BASE    = '0,
    parameter logic [7:0]            CLAIM_OFFSET = 8'h18
`ifdef APB4_PLIC_TIMEOUT_EN
    ,
    parameter int unsigned           TIMEOUT      = 16
`endif
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      ext_irq_i,
    output logic                      irq_valid_o,
    output logic [ID_WIDTH-1:0]       irq_id_o,
    input  logic                      irq_done_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    output logic                      rsp_valid_o,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      err_o,
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [2:0]                pprot,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] CLAIM_ADDR = PLIC_BASE + ADDR_WIDTH'(CLAIM_OFFSET);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_NOTIFY = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_CLAIM = 2'd0,
        OWN_COMP  = 2'd1,
        OWN_GEN   = 2'd2
    } owner_t;

    state_t state;
    owner_t owner;
    logic   tok_gen;        // 1: a waiting generic request wins over a pending claim

    logic                  xfer_end_c;
    logic                  xfer_err_c;
    logic                  tmo_hit_c;
    logic [DATA_WIDTH-1:0] xfer_rdata_c;
    logic [ID_WIDTH-1:0]   claim_id_c;

    assign pprot = 3'b000;

`ifdef APB4_PLIC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Counts ACCESS cycles without pready; cleared whenever the bus is not in ACCESS.
    always_ff @(posedge pclk) begin
        if (preset || (state != S_ACCESS)) begin
            tmo_cnt <= '0;
        end else if (!pready) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT-th stalled ACCESS cycle.
    assign tmo_hit_c = (state == S_ACCESS) && !pready && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Transfer end: a normal pready cycle, or an aborted one treated as a slave error with zero data.
    always_comb begin
        xfer_end_c   = (state == S_ACCESS) && (pready || tmo_hit_c);
        xfer_err_c   = pready ? pslverr : 1'b1;
        xfer_rdata_c = pready ? prdata : '0;
        claim_id_c   = xfer_rdata_c[ID_WIDTH-1:0];
    end

    // Main sequencer with registered APB and core-side outputs.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= S_IDLE;
            owner       <= OWN_CLAIM;
            tok_gen     <= 1'b0;
            irq_valid_o <= 1'b0;
            irq_id_o    <= '0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            err_o       <= 1'b0;
            paddr       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
        end else begin
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            err_o       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (ext_irq_i && !(req_valid_i && tok_gen)) begin
                        owner  <= OWN_CLAIM;
                        paddr  <= CLAIM_ADDR;
                        pwrite <= 1'b0;
                        pwdata <= '0;
                        pstrb  <= '0;
                        psel   <= 1'b1;
                        state  <= S_SETUP;
                    end else if (req_valid_i) begin
                        owner       <= OWN_GEN;
                        paddr       <= req_addr_i;
                        pwrite      <= req_write_i;
                        pwdata      <= req_wdata_i;
                        pstrb       <= req_write_i ? {STRB_W{1'b1}} : '0;
                        psel        <= 1'b1;
                        req_ready_o <= 1'b1;
                        state       <= S_SETUP;
                        // Generic request won over a pending claim: hand priority back.
                        if (ext_irq_i) begin
                            tok_gen <= 1'b0;
                        end
                    end
                end

                S_SETUP: begin
                    penable <= 1'b1;
                    state   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (xfer_end_c) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= S_GAP;
                        case (owner)
                            OWN_CLAIM: begin
                                if (xfer_err_c) begin
                                    err_o <= 1'b1;
                                end else if (claim_id_c != '0) begin
                                    irq_id_o    <= claim_id_c;
                                    irq_valid_o <= 1'b1;
                                    state       <= S_NOTIFY;
                                end
                            end
                            OWN_COMP: begin
                                err_o   <= xfer_err_c;
                                tok_gen <= 1'b1;
                            end
                            OWN_GEN: begin
                                rsp_valid_o <= 1'b1;
                                rsp_err_o   <= xfer_err_c;
                                rsp_rdata_o <= pwrite ? '0 : xfer_rdata_c;
                            end
                            default: ;
                        endcase
                    end
                end

                S_NOTIFY: begin
                    if (irq_done_i) begin
                        irq_valid_o <= 1'b0;
                        owner       <= OWN_COMP;
                        paddr       <= CLAIM_ADDR;
                        pwrite      <= 1'b1;
                        pwdata      <= DATA_WIDTH'(irq_id_o);
                        pstrb       <= {STRB_W{1'b1}};
                        psel        <= 1'b1;
                        state       <= S_SETUP;
                    end
                end

                // One quiet cycle so the PLIC's registered ext_irq can settle.
                S_GAP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
